// File: rtl/dm_access_if.sv
// Request/response and data-memory bus between the MEM stage, the access
// controller and the word-addressed DM.
interface dm_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic [31:0] dm_addr;
    logic        dm_we;
    logic [31:0] dm_wdata;
    logic [31:0] dm_pc;
    logic [31:0] dm_rdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic [31:0] err_pc;

    // Environment side: pipeline requester plus the DM itself.
    modport master (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
        output dm_rdata,
        input  req_ready, dm_addr, dm_we, dm_wdata, dm_pc,
        input  rdata, rdata_valid, err, err_pc
    );

    // Access controller side.
    modport slave (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
        input  dm_rdata,
        output req_ready, dm_addr, dm_we, dm_wdata, dm_pc,
        output rdata, rdata_valid, err, err_pc
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// MEM-stage data memory access controller. Loads are single cycle,
// word stores are single cycle, and byte/half stores run a two-cycle
// read-modify-write because the DM only accepts whole-word writes.
module dm_access_ctrl #(
    parameter int DM_WORDS = 1024
) (
    input logic       clk,
    input logic       reset,
    dm_access_if.slave bus
);
    typedef enum logic {IDLE, MERGE} state_t;

    localparam logic [32:0] ADDR_LIMIT = 33'(DM_WORDS) << 2;

    state_t      state, state_nxt;
    logic        req_bad, accept, acc_ok, is_load, is_wstore, is_sstore;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val, merge_val;
    logic [31:0] merge_q, addr_q, pc_q;
    logic [31:0] rdata_q, err_pc_q;
    logic        rdata_valid_q, err_q;
    logic        req_ready_c, dm_we_c;
    logic [31:0] dm_addr_c, dm_wdata_c, dm_pc_c;

    // Request classification: illegal size, misalignment or out-of-range.
    always_comb begin
        req_bad = (bus.req_size == 2'b11) ||
                  (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                  (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
                  ({1'b0, bus.req_addr} >= ADDR_LIMIT);
        accept    = (state == IDLE) && bus.req_valid;
        acc_ok    = accept && !req_bad;
        is_load   = acc_ok && !bus.req_we;
        is_wstore = acc_ok && bus.req_we && (bus.req_size == 2'b10);
        is_sstore = acc_ok && bus.req_we && (bus.req_size != 2'b10);
    end

    // Lane extraction and sign/zero extension of the DM read word.
    always_comb begin
        case (bus.req_addr[1:0])
            2'd0:    byte_sel = bus.dm_rdata[7:0];
            2'd1:    byte_sel = bus.dm_rdata[15:8];
            2'd2:    byte_sel = bus.dm_rdata[23:16];
            default: byte_sel = bus.dm_rdata[31:24];
        endcase
        half_sel = bus.req_addr[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
        case (bus.req_size)
            2'b00:   load_val = {{24{bus.req_sign & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{bus.req_sign & half_sel[15]}}, half_sel};
            default: load_val = bus.dm_rdata;
        endcase
    end

    // Merge the store lane into the current DM word for the RMW write.
    always_comb begin
        merge_val = bus.dm_rdata;
        if (bus.req_size == 2'b00) begin
            case (bus.req_addr[1:0])
                2'd0:    merge_val[7:0]   = bus.req_wdata[7:0];
                2'd1:    merge_val[15:8]  = bus.req_wdata[7:0];
                2'd2:    merge_val[23:16] = bus.req_wdata[7:0];
                default: merge_val[31:24] = bus.req_wdata[7:0];
            endcase
        end else if (bus.req_addr[1]) begin
            merge_val[31:16] = bus.req_wdata[15:0];
        end else begin
            merge_val[15:0] = bus.req_wdata[15:0];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: only an accepted sub-word store enters MERGE, for one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (is_sstore) state_nxt = MERGE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs; reset gates the write so a pending merge is dropped at once.
    always_comb begin
        req_ready_c = 1'b0;
        dm_we_c     = 1'b0;
        dm_addr_c   = {bus.req_addr[31:2], 2'b00};
        dm_wdata_c  = bus.req_wdata;
        dm_pc_c     = bus.req_pc;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                dm_we_c     = is_wstore;
            end
            default: begin
                dm_we_c    = 1'b1;
                dm_addr_c  = addr_q;
                dm_wdata_c = merge_q;
                dm_pc_c    = pc_q;
            end
        endcase
        if (reset) dm_we_c = 1'b0;
    end

    // Load result, error report and RMW holding registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_pc_q      <= '0;
            merge_q       <= '0;
            addr_q        <= '0;
            pc_q          <= '0;
        end else begin
            rdata_valid_q <= is_load;
            err_q         <= accept && req_bad;
            if (is_load)          rdata_q  <= load_val;
            if (accept && req_bad) err_pc_q <= bus.req_pc;
            if (is_sstore) begin
                merge_q <= merge_val;
                addr_q  <= {bus.req_addr[31:2], 2'b00};
                pc_q    <= bus.req_pc;
            end
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.dm_we       = dm_we_c;
    assign bus.dm_addr     = dm_addr_c;
    assign bus.dm_wdata    = dm_wdata_c;
    assign bus.dm_pc       = dm_pc_c;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.err         = err_q;
    assign bus.err_pc      = err_pc_q;
endmodule
